// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - shared types and default timing for the WS2812 transmit path
// Contents:
//   ws2812_tx_state_t  transmitter FSM states
//   tx_pixel_t         packed pixel in wire order {g, r, b}
//   WS2812_*_CYC       default timing in clocks at 50 MHz
//   rgb_to_grb()       reorders an R/G/B word into wire order
package pipeline_types;

  localparam int WS2812_T0H_CYC   = 20;
  localparam int WS2812_T1H_CYC   = 40;
  localparam int WS2812_BIT_CYC   = 63;
  localparam int WS2812_RESET_CYC = 2750;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_BIT_HIGH,
    WS_BIT_LOW,
    WS_LATCH
  } ws2812_tx_state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } tx_pixel_t;

  function automatic tx_pixel_t rgb_to_grb(input logic [23:0] rgb);
    tx_pixel_t p;
    p.g = rgb[15:8];
    p.r = rgb[23:16];
    p.b = rgb[7:0];
    return p;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// rtl/ws2812_bit_timer.sv - loadable down-counter timing one high, low or latch interval
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_load            load i_load_val this cycle (takes priority over counting)
//   i_load_val        interval length in clocks, must be >= 1
//   o_done            the current cycle is the last one of the loaded interval
module ws2812_bit_timer #(
  parameter int CNT_W = 12
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A load of N makes the interval span N cycles: count runs N..1 and the
  // cycle holding 1 is the last. Counting stops at 0 so it never wraps.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = (count_q <= CNT_W'(1));

endmodule

// File: rtl/ws2812_transmitter.sv
// rtl/ws2812_transmitter.sv - serialises 24-bit GRB pixels into the WS2812 NRZ waveform
// Build option: define WS2812_TX_RGB_REORDER_EN to accept R/G/B input words and
// reorder them to G/R/B wire order at load; otherwise input is already G/R/B.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_pixel_data      pixel word, MSB sent first
//   i_pixel_valid     pixel word valid
//   o_pixel_ready     a pixel is accepted this cycle if valid
//   i_latch           one-cycle request for the end-of-frame low period
//   o_dout            registered serial data to the LED chain
//   o_busy            transmitter is not idle
module ws2812_transmitter
  import pipeline_types::*;
#(
  parameter int T0H_CYC   = WS2812_T0H_CYC,
  parameter int T1H_CYC   = WS2812_T1H_CYC,
  parameter int BIT_CYC   = WS2812_BIT_CYC,
  parameter int RESET_CYC = WS2812_RESET_CYC
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [23:0] i_pixel_data,
  input  logic        i_pixel_valid,
  output logic        o_pixel_ready,
  input  logic        i_latch,
  output logic        o_dout,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(((BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC) + 1);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC > BIT_CYC))
  begin : g_bad_timing
    $fatal(1, "ws2812_transmitter: inconsistent timing parameters");
  end

  ws2812_tx_state_t state_q, state_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             latch_pending_q, latch_pending_d;
  logic             dout_q, dout_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  logic [23:0]      load_word;
  logic             ready;
  logic             accept;
  logic             latch_req;

`ifdef WS2812_TX_RGB_REORDER_EN
  assign load_word = rgb_to_grb(i_pixel_data);
`else
  assign load_word = i_pixel_data;
`endif

  function automatic logic [CNT_W-1:0] th_of(input logic b);
    return b ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
  endfunction

  ws2812_bit_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (tmr_load),
    .i_load_val(tmr_val),
    .o_done    (tmr_done)
  );

  always_comb begin
    ready = ((state_q == WS_IDLE) ||
             (state_q == WS_BIT_LOW && tmr_done && bit_cnt_q == 5'd0)) &&
            !latch_pending_q;
    accept = i_pixel_valid && ready;
    // A latch raised this very cycle counts, so IDLE can enter LATCH next cycle.
    latch_req = latch_pending_q || i_latch;

    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      WS_IDLE: begin
        if (accept) begin
          state_d   = WS_BIT_HIGH;
          shift_d   = load_word;
          bit_cnt_d = 5'd23;
          tmr_load  = 1'b1;
          tmr_val   = th_of(load_word[23]);
        end else if (latch_req) begin
          state_d  = WS_LATCH;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RESET_CYC);
        end
      end
      WS_BIT_HIGH: begin
        if (tmr_done) begin
          state_d  = WS_BIT_LOW;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(BIT_CYC) - th_of(shift_q[23]);
        end
      end
      WS_BIT_LOW: begin
        if (tmr_done) begin
          if (bit_cnt_q != 5'd0) begin
            state_d   = WS_BIT_HIGH;
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
            tmr_load  = 1'b1;
            tmr_val   = th_of(shift_q[22]);
          end else if (accept) begin
            // Seamless reload: next rising edge lands exactly one bit period later.
            state_d   = WS_BIT_HIGH;
            shift_d   = load_word;
            bit_cnt_d = 5'd23;
            tmr_load  = 1'b1;
            tmr_val   = th_of(load_word[23]);
          end else if (latch_req) begin
            state_d  = WS_LATCH;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(RESET_CYC);
          end else begin
            state_d = WS_IDLE;
          end
        end
      end
      WS_LATCH: begin
        if (tmr_done) begin
          state_d = WS_IDLE;
        end
      end
      default: begin
        state_d = WS_IDLE;
      end
    endcase

    // Requests arriving during LATCH are absorbed by the latch in progress.
    if (state_q == WS_LATCH) begin
      latch_pending_d = !tmr_done;
    end else begin
      latch_pending_d = latch_pending_q || i_latch;
    end

    dout_d = (state_d == WS_BIT_HIGH);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q         <= WS_IDLE;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      latch_pending_q <= 1'b0;
      dout_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      latch_pending_q <= latch_pending_d;
      dout_q          <= dout_d;
    end
  end

  assign o_pixel_ready = ready;
  assign o_dout        = dout_q;
  assign o_busy        = (state_q != WS_IDLE);

endmodule
